// File: rtl/axi_loader_req_gen.sv
// Request generator for one axi_master_loader: fills the loader FIFO with LFSR-derived
// {id, write, axlen} entries, kicks the loader, waits for it to drain, and repeats per round.
module axi_loader_req_gen #(
    parameter int          MAX_ID_WIDTH = 5,
    parameter int          FIFO_DEPTH   = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    cfg_valid_i,
    input  logic [7:0]              cfg_num_req_i,
    input  logic [7:0]              cfg_rounds_i,
    input  logic [7:0]              cfg_depth_i,
    input  logic [7:0]              cfg_wr_thr_i,
    input  logic [7:0]              cfg_len_mask_i,
    input  logic [MAX_ID_WIDTH-1:0] cfg_id_mask_i,
    input  logic [15:0]             cfg_seed_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [MAX_ID_WIDTH-1:0] id_o,
    output logic                    write_o,
    output logic [7:0]              axlen_o,
    output logic                    fifo_push_o,
    output logic [7:0]              req_depth_o,
    output logic                    start_o,
    input  logic                    loader_idle_i,
    output logic [15:0]             wr_count_o,
    output logic [15:0]             rd_count_o
);

    localparam logic [7:0]  FIFO_DEPTH_C = 8'(FIFO_DEPTH);
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_KICK,
        S_RUN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              num_q, num_d;
    logic [7:0]              rounds_q, rounds_d;
    logic [7:0]              depth_q, depth_d;
    logic [7:0]              thr_q, thr_d;
    logic [7:0]              len_mask_q, len_mask_d;
    logic [MAX_ID_WIDTH-1:0] id_mask_q, id_mask_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [7:0]              push_cnt_q, push_cnt_d;
    logic [7:0]              round_cnt_q, round_cnt_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic [15:0]             rd_cnt_q, rd_cnt_d;

    logic [7:0]              num_clamp;
    logic [15:0]             lfsr_next;
    logic                    ent_write;
    logic [MAX_ID_WIDTH-1:0] ent_id;
    logic [7:0]              ent_len;
    logic                    push;

    // The loader FIFO cannot push back, so the per-round count is capped at its depth.
    assign num_clamp = (cfg_num_req_i > FIFO_DEPTH_C) ? FIFO_DEPTH_C : cfg_num_req_i;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    assign ent_write = ({1'b0, lfsr_q[15:9]} < thr_q);
    assign ent_id    = lfsr_q[8 +: MAX_ID_WIDTH] & id_mask_q;
    assign ent_len   = lfsr_q[7:0] & len_mask_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        rounds_d    = rounds_q;
        depth_d     = depth_q;
        thr_d       = thr_q;
        len_mask_d  = len_mask_q;
        id_mask_d   = id_mask_q;
        lfsr_d      = lfsr_q;
        push_cnt_d  = push_cnt_q;
        round_cnt_d = round_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        push        = 1'b0;
        start_o     = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    num_d       = num_clamp;
                    rounds_d    = (cfg_rounds_i == 8'd0) ? 8'd1 : cfg_rounds_i;
                    depth_d     = (cfg_depth_i == 8'd0) ? 8'd1 : cfg_depth_i;
                    thr_d       = cfg_wr_thr_i;
                    len_mask_d  = cfg_len_mask_i;
                    id_mask_d   = cfg_id_mask_i;
                    lfsr_d      = (cfg_seed_i == 16'h0000) ? LFSR_SEED : cfg_seed_i;
                    push_cnt_d  = 8'd0;
                    round_cnt_d = 8'd0;
                    wr_cnt_d    = 16'd0;
                    rd_cnt_d    = 16'd0;
                    state_d     = (num_clamp == 8'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                push       = 1'b1;
                lfsr_d     = lfsr_next;
                push_cnt_d = push_cnt_q + 8'd1;
                if (ent_write) begin
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
                end else begin
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
                end
                if ((push_cnt_q + 8'd1) == num_q) state_d = S_KICK;
            end
            S_KICK: begin
                // Hold start until the loader shows it has left idle.
                start_o = 1'b1;
                if (!loader_idle_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (loader_idle_i) begin
                    round_cnt_d = round_cnt_q + 8'd1;
                    if ((round_cnt_q + 8'd1) == rounds_q) begin
                        state_d = S_DONE;
                    end else begin
                        push_cnt_d = 8'd0;
                        state_d    = S_FILL;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= S_IDLE;
            num_q       <= 8'd0;
            rounds_q    <= 8'd1;
            depth_q     <= 8'd1;
            thr_q       <= 8'd0;
            len_mask_q  <= 8'd0;
            id_mask_q   <= '0;
            lfsr_q      <= LFSR_SEED;
            push_cnt_q  <= 8'd0;
            round_cnt_q <= 8'd0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            rounds_q    <= rounds_d;
            depth_q     <= depth_d;
            thr_q       <= thr_d;
            len_mask_q  <= len_mask_d;
            id_mask_q   <= id_mask_d;
            lfsr_q      <= lfsr_d;
            push_cnt_q  <= push_cnt_d;
            round_cnt_q <= round_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign fifo_push_o = push;
    assign id_o        = push ? ent_id : '0;
    assign write_o     = push ? ent_write : 1'b0;
    assign axlen_o     = push ? ent_len : 8'd0;
    assign req_depth_o = depth_q;
    assign wr_count_o  = wr_cnt_q;
    assign rd_count_o  = rd_cnt_q;

endmodule
